cond_unit: RTL
==============

# cond_unit

Execute-stage condition unit, directly downstream of the ALU. It holds the architectural NZCV flag register and evaluates each instruction's 4-bit condition field against the current flags. It gates the instruction's side effects (register write, memory write, PC redirect) and updates the flags from the ALU flag outputs when the instruction executes and requests a flag write.

## Interface
Parameters:
- None. Widths are fixed by the ISA.

Ports:
- CLK  in  1  sole clock; all state updates on the rising edge.
- Reset  in  1  asynchronous, active-high; clears all state immediately.
- ValidE  in  1  an instruction occupies the Execute stage. Low means bubble or flushed slot.
- StallE  in  1  Execute stage is held this cycle; no state update.
- CondE  in  4  instruction condition field (bits 31:28).
- FlagWriteE  in  2  bit1 requests an N,Z update; bit0 requests a C,V update.
- ALUFlags  in  4  {N,Z,C,V} from the ALU for the instruction in Execute.
- PCSrcE, RegWriteE, MemWriteE  in  1 each  ungated decoder controls.
- PCSrcCond, RegWriteCond, MemWriteCond  out  1 each  gated controls.
- CondExE  out  1  the instruction executes this cycle.
- Flags  out  4  registered {N,Z,C,V}.

## Operation
- CondExE = ValidE & condition_true(CondE, Flags). The condition is evaluated on the registered Flags, never on ALUFlags.
- Condition table, with N,Z,C,V taken from Flags:
  - 0000 EQ: Z
  - 0001 NE: ~Z
  - 0010 CS: C
  - 0011 CC: ~C
  - 0100 MI: N
  - 0101 PL: ~N
  - 0110 VS: V
  - 0111 VC: ~V
  - 1000 HI: C&~Z
  - 1001 LS: ~C|Z
  - 1010 GE: N==V
  - 1011 LT: N!=V
  - 1100 GT: ~Z&(N==V)
  - 1101 LE: Z|(N!=V)
  - 1110 AL: 1
  - 1111 NV: 0 (ARMv3 "never")
- Gated outputs: XCond = XE & CondExE, for each of PCSrc, RegWrite and MemWrite.
- Flag update at the rising edge when CondExE & ~StallE:
  - If FlagWriteE[1]: Flags[3:2] <= ALUFlags[3:2].
  - If FlagWriteE[0]: Flags[1:0] <= ALUFlags[1:0].
  - The two halves are independent. FlagWriteE=10 (logical ops) leaves C,V unchanged.
- No update occurs when:
  - CondExE=0 (condition failed, bubble, or NV), or
  - StallE=1.
- Gated outputs still reflect the stalled instruction combinationally. Downstream pipeline registers are held by their own stall.

## Timing
- Reset value: Flags=4'b0000. Consequently:
  - EQ evaluates false out of reset and NE evaluates true.
  - With ValidE=0, all gated outputs are 0.
- Gated outputs and CondExE are combinational: zero-cycle latency from CondE, ValidE and the control inputs.
- Flag update has one-cycle latency: an instruction updating flags in cycle t is visible to the condition of the instruction in Execute in cycle t+1. No bypass is needed, because flags are produced and consumed in the same stage.
- Back-to-back case: a flag-setting conditional instruction (e.g. ADDEQS) evaluates on the old flags, then overwrites them. The next instruction sees the new flags.
- Stall followed by release: the held instruction re-evaluates on unchanged Flags and updates exactly once, on the first non-stalled edge.
- Reset asserted mid-operation: Flags clear asynchronously and gated outputs follow the cleared flags in the same cycle. An update on the edge coincident with reset is lost.
- No path from ALUFlags to any output other than through the Flags register. Only the ALU→Flags register path loads ALU timing.

## Structure
- Shared package arm_pkg holds:
  - localparams for the 16 condition encodings (COND_EQ … COND_NV);
  - FlagWrite bit positions (FW_NZ=1, FW_CV=0);
  - the flag bit indices (FLAG_N=3, FLAG_Z=2, FLAG_C=1, FLAG_V=0).
- One combinational sub-module, cond_check (inputs Cond[3:0] and Flags[3:0], output CondEx). It is reused by the branch predictor/verification model.
- cond_unit contains the flag register, the gating logic, and one cond_check instance.

## Test plan
- Reset: assert Reset with any inputs → Flags=0000. CondE=0000 gives CondExE=0; CondE=0001 with ValidE=1, RegWriteE=1 gives RegWriteCond=1.
- SUBS 5−5: CondE=1110, FlagWriteE=11, ALUFlags=0110, then next cycle CondE=0000 with MemWriteE=1 → Flags=0110, CondExE=1, MemWriteCond=1. With CondE=0001 instead → all gated outputs 0.
- Partial write: Flags=0011, then ANDS with FlagWriteE=10, ALUFlags=1000 → Flags=1011 (C,V preserved).
- Failed condition blocks update: Flags=0000, CondE=0000, FlagWriteE=11, ALUFlags=1111 → CondExE=0, Flags stay 0000, PCSrcCond=0.
- Stall: CondE=1110, FlagWriteE=11, ALUFlags=1001, StallE=1 for 3 cycles, then 0 → Flags unchanged during the stall, 1001 after the first released edge. RegWriteCond=1 throughout.
- Exhaustive: all 16 CondE × all 16 Flags values (preloaded via AL flag-setting ops) → CondExE matches the table. NV is always 0; ValidE=0 forces 0.

Source files
------------

// File: rtl/arm_pkg.sv
// Shared ISA constants for the execute-stage condition logic:
// condition-field encodings, FlagWrite bit positions and NZCV bit indices.
package arm_pkg;

    // Condition field encodings (instruction bits 31:28)
    localparam logic [3:0] COND_EQ = 4'b0000;
    localparam logic [3:0] COND_NE = 4'b0001;
    localparam logic [3:0] COND_CS = 4'b0010;
    localparam logic [3:0] COND_CC = 4'b0011;
    localparam logic [3:0] COND_MI = 4'b0100;
    localparam logic [3:0] COND_PL = 4'b0101;
    localparam logic [3:0] COND_VS = 4'b0110;
    localparam logic [3:0] COND_VC = 4'b0111;
    localparam logic [3:0] COND_HI = 4'b1000;
    localparam logic [3:0] COND_LS = 4'b1001;
    localparam logic [3:0] COND_GE = 4'b1010;
    localparam logic [3:0] COND_LT = 4'b1011;
    localparam logic [3:0] COND_GT = 4'b1100;
    localparam logic [3:0] COND_LE = 4'b1101;
    localparam logic [3:0] COND_AL = 4'b1110;
    localparam logic [3:0] COND_NV = 4'b1111;

    // FlagWrite request bits
    localparam int FW_NZ = 1;
    localparam int FW_CV = 0;

    // Bit positions inside the {N,Z,C,V} flag vector
    localparam int FLAG_N = 3;
    localparam int FLAG_Z = 2;
    localparam int FLAG_C = 1;
    localparam int FLAG_V = 0;

endpackage

// File: rtl/cond_check.sv
// Pure combinational evaluation of a 4-bit condition field against NZCV.
// Shared with the branch predictor and the verification model.
module cond_check
    import arm_pkg::*;
(
    input  logic [3:0] Cond,
    input  logic [3:0] Flags,
    output logic       CondEx
);

    logic n_flag;
    logic z_flag;
    logic c_flag;
    logic v_flag;
    logic ge_flag;

    assign n_flag  = Flags[FLAG_N];
    assign z_flag  = Flags[FLAG_Z];
    assign c_flag  = Flags[FLAG_C];
    assign v_flag  = Flags[FLAG_V];
    // Signed greater-or-equal: N and V agree
    assign ge_flag = (n_flag == v_flag);

    // Decode the condition field into a single pass/fail bit
    always_comb begin
        CondEx = 1'b0;
        case (Cond)
            COND_EQ: CondEx = z_flag;
            COND_NE: CondEx = ~z_flag;
            COND_CS: CondEx = c_flag;
            COND_CC: CondEx = ~c_flag;
            COND_MI: CondEx = n_flag;
            COND_PL: CondEx = ~n_flag;
            COND_VS: CondEx = v_flag;
            COND_VC: CondEx = ~v_flag;
            COND_HI: CondEx = c_flag & ~z_flag;
            COND_LS: CondEx = ~c_flag | z_flag;
            COND_GE: CondEx = ge_flag;
            COND_LT: CondEx = ~ge_flag;
            COND_GT: CondEx = ~z_flag & ge_flag;
            COND_LE: CondEx = z_flag | ~ge_flag;
            COND_AL: CondEx = 1'b1;
            COND_NV: CondEx = 1'b0;
            default: CondEx = 1'b0;
        endcase
    end

endmodule

// File: rtl/cond_unit.sv
// Execute-stage condition unit: owns the architectural NZCV register,
// gates instruction side effects on the condition result, and loads
// flags from the ALU when a passing, non-stalled instruction asks for it.
module cond_unit
    import arm_pkg::*;
(
    input  logic       CLK,
    input  logic       Reset,
    input  logic       ValidE,
    input  logic       StallE,
    input  logic [3:0] CondE,
    input  logic [1:0] FlagWriteE,
    input  logic [3:0] ALUFlags,
    input  logic       PCSrcE,
    input  logic       RegWriteE,
    input  logic       MemWriteE,
    output logic       PCSrcCond,
    output logic       RegWriteCond,
    output logic       MemWriteCond,
    output logic       CondExE,
    output logic [3:0] Flags
);

    logic [3:0] flags_q;
    logic       cond_pass;
    logic       flag_load;

    // Condition is judged on the registered flags only; ALUFlags never
    // reaches an output combinationally.
    cond_check u_cond_check (
        .Cond   (CondE),
        .Flags  (flags_q),
        .CondEx (cond_pass)
    );

    assign CondExE      = ValidE & cond_pass;
    assign PCSrcCond    = PCSrcE & CondExE;
    assign RegWriteCond = RegWriteE & CondExE;
    assign MemWriteCond = MemWriteE & CondExE;
    assign Flags        = flags_q;

    // A held instruction keeps re-evaluating but only commits once released
    assign flag_load = CondExE & ~StallE;

    // NZ and CV halves load independently so logical ops keep C and V
    always_ff @(posedge CLK or posedge Reset) begin
        if (Reset) begin
            flags_q <= 4'b0000;
        end else if (flag_load) begin
            if (FlagWriteE[FW_NZ]) begin
                flags_q[FLAG_N:FLAG_Z] <= ALUFlags[FLAG_N:FLAG_Z];
            end
            if (FlagWriteE[FW_CV]) begin
                flags_q[FLAG_C:FLAG_V] <= ALUFlags[FLAG_C:FLAG_V];
            end
        end
    end

endmodule
